// File: rtl/jt10_adpcma_dec_if.sv
// Slot bus between the ADPCM-A address counter and the nibble decoder,
// carrying ROM byte and strobes in, tagged PCM sample out.
interface jt10_adpcma_dec_if;
  logic        cen;
  logic [5:0]  cur_ch;
  logic [7:0]  rom_data;
  logic        sel;
  logic        decon;
  logic        clr;
  logic [11:0] pcm;
  logic [5:0]  pcm_ch;

  modport master (
    output cen, cur_ch, rom_data, sel, decon, clr,
    input  pcm, pcm_ch
  );

  modport slave (
    input  cen, cur_ch, rom_data, sel, decon, clr,
    output pcm, pcm_ch
  );
endinterface

// File: rtl/jt10_adpcma_dec.sv
// Six-slot time-multiplexed ADPCM-A nibble decoder.
// Per-channel {acc, idx} state lives in a rotating ring of registers.
module jt10_adpcma_dec #(
  parameter int CHANNELS = 6
) (
  input logic              clk,
  input logic              rst,
  jt10_adpcma_dec_if.slave bus
);

  logic [CHANNELS-1:0][11:0] acc_q, acc_d;
  logic [CHANNELS-1:0][5:0]  idx_q, idx_d;
  logic [11:0]               pcm_q, pcm_d;
  logic [5:0]                pcm_ch_q, pcm_ch_d;

  logic [11:0]       head_acc;
  logic [5:0]        head_idx;
  logic [3:0]        nib;
  logic [2:0]        mag;
  logic [10:0]       step;
  logic [14:0]       prod;
  logic [11:0]       delta;
  logic signed [6:0] adj;
  logic signed [6:0] idx_sum;
  logic [5:0]        idx_clamp;
  logic [11:0]       new_acc;
  logic [5:0]        new_idx;
  logic              unused_lsb;

  function automatic logic [10:0] step_lut(
    input logic [5:0] i
  );
    case (i)
      6'd0:  step_lut = 11'd16;
      6'd1:  step_lut = 11'd17;
      6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;
      6'd4:  step_lut = 11'd23;
      6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;
      6'd7:  step_lut = 11'd31;
      6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;
      6'd10: step_lut = 11'd41;
      6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;
      6'd13: step_lut = 11'd55;
      6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;
      6'd16: step_lut = 11'd73;
      6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;
      6'd19: step_lut = 11'd97;
      6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;
      6'd22: step_lut = 11'd130;
      6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;
      6'd25: step_lut = 11'd173;
      6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;
      6'd28: step_lut = 11'd230;
      6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;
      6'd31: step_lut = 11'd307;
      6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;
      6'd34: step_lut = 11'd408;
      6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;
      6'd37: step_lut = 11'd544;
      6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;
      6'd40: step_lut = 11'd724;
      6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;
      6'd43: step_lut = 11'd963;
      6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166;
      6'd46: step_lut = 11'd1282;
      6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  // Slot datapath: the ring head always belongs to cur_ch.
  always_comb begin
    head_acc = acc_q[0];
    head_idx = idx_q[0];
    nib  = bus.sel ? bus.rom_data[3:0] : bus.rom_data[7:4];
    mag  = nib[2:0];
    step = step_lut(head_idx);
    // (2*mag+1)*step as shift-add
    prod = {4'd0, step}
         + (mag[0] ? {3'd0, step, 1'b0} : 15'd0)
         + (mag[1] ? {2'd0, step, 2'b0} : 15'd0)
         + (mag[2] ? {1'd0, step, 3'b0} : 15'd0);
    delta      = prod[14:3];
    unused_lsb = ^prod[2:0];
    unique case (mag)
      3'd4:    adj = 7'sd2;
      3'd5:    adj = 7'sd5;
      3'd6:    adj = 7'sd7;
      3'd7:    adj = 7'sd9;
      default: adj = -7'sd1;
    endcase
    idx_sum = $signed({1'b0, head_idx}) + adj;
    if (idx_sum < 7'sd0)
      idx_clamp = 6'd0;
    else if (idx_sum > 7'sd48)
      idx_clamp = 6'd48;
    else
      idx_clamp = idx_sum[5:0];
    if (bus.clr) begin
      new_acc = 12'd0;
      new_idx = 6'd0;
    end else if (bus.decon) begin
      new_acc = nib[3] ? head_acc - delta
                       : head_acc + delta;
      new_idx = idx_clamp;
    end else begin
      new_acc = head_acc;
      new_idx = head_idx;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    pcm_d    = pcm_q;
    pcm_ch_d = pcm_ch_q;
    if (bus.cen) begin
      for (int i = 0; i < CHANNELS - 1; i++) begin
        acc_d[i] = acc_q[i+1];
        idx_d[i] = idx_q[i+1];
      end
      acc_d[CHANNELS-1] = new_acc;
      idx_d[CHANNELS-1] = new_idx;
      pcm_d    = new_acc;
      pcm_ch_d = bus.cur_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      idx_q    <= '0;
      pcm_q    <= 12'd0;
      pcm_ch_q <= 6'b000001;
    end else begin
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      pcm_q    <= pcm_d;
      pcm_ch_q <= pcm_ch_d;
    end
  end

  assign bus.pcm    = pcm_q;
  assign bus.pcm_ch = pcm_ch_q;

endmodule

// File: tb/tb_jt10_adpcma_dec.sv
// Scoreboard bench for jt10_adpcma_dec against a
// behavioural ADPCM-A channel model.
module tb_jt10_adpcma_dec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt10_adpcma_dec_if bus ();

  jt10_adpcma_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int steps[49] = '{
    16, 17, 19, 21, 23, 25, 28, 31, 34, 37,
    41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
    107, 118, 130, 143, 157, 173, 190, 209,
    230, 253, 279, 307, 337, 371, 408, 449,
    494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552};
  int adjt[8] = '{-1, -1, -1, -1, 2, 5, 7, 9};

  logic [11:0] m_acc[6];
  int          m_idx[6];
  int          ch;
  logic [17:0] exp_q[$];
  logic [11:0] last_pcm;
  logic [5:0]  last_ch;
  logic [11:0] prev2;
  logic [11:0] diff;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_acc[i] = 12'd0;
      m_idx[i] = 0;
    end
    ch       = 0;
    last_pcm = 12'd0;
    last_ch  = 6'b000001;
  endtask

  task automatic slot(input logic [7:0] d,
                      input logic s,
                      input logic de,
                      input logic c);
    logic [3:0]  n;
    logic [17:0] e;
    int          mag;
    int          delta;
    int          ni;
    n = s ? d[3:0] : d[7:4];
    if (c) begin
      m_acc[ch] = 12'd0;
      m_idx[ch] = 0;
    end else if (de) begin
      mag   = int'(n[2:0]);
      delta = ((2 * mag + 1) * steps[m_idx[ch]]) / 8;
      if (n[3])
        m_acc[ch] = m_acc[ch] - 12'(delta);
      else
        m_acc[ch] = m_acc[ch] + 12'(delta);
      ni = m_idx[ch] + adjt[mag];
      if (ni < 0) ni = 0;
      if (ni > 48) ni = 48;
      m_idx[ch] = ni;
    end
    exp_q.push_back({6'(1 << ch), m_acc[ch]});
    bus.cen      = 1'b1;
    bus.cur_ch   = 6'(1 << ch);
    bus.rom_data = d;
    bus.sel      = s;
    bus.decon    = de;
    bus.clr      = c;
    @(posedge clk);
    #1;
    bus.cen = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("pcm", 32'(bus.pcm), 32'(e[11:0]));
      check("pcm_ch", 32'(bus.pcm_ch), 32'(e[17:12]));
      last_pcm = e[11:0];
      last_ch  = e[17:12];
    end
    ch = (ch + 1) % 6;
  endtask

  task automatic slot_n(input logic [3:0] n,
                        input logic de,
                        input logic c);
    logic       s;
    logic [3:0] r;
    s = 1'($urandom);
    r = 4'($urandom);
    slot(s ? {r, n} : {n, r}, s, de, c);
  endtask

  task automatic skip();
    slot_n(4'($urandom), 1'b0, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      bus.cen      = 1'b0;
      bus.cur_ch   = 6'($urandom);
      bus.rom_data = 8'($urandom);
      bus.sel      = 1'($urandom);
      bus.decon    = 1'($urandom);
      bus.clr      = 1'($urandom);
      @(posedge clk);
      #1;
      check("idle_pcm", 32'(bus.pcm), 32'(last_pcm));
      check("idle_ch", 32'(bus.pcm_ch), 32'(last_ch));
    end
  endtask

  task automatic rand_slot();
    logic c;
    c = ($urandom_range(0, 15) == 0);
    idle(3);
    slot_n(4'($urandom), 1'($urandom), c);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.cen      = 1'b0;
    bus.cur_ch   = 6'd0;
    bus.rom_data = 8'd0;
    bus.sel      = 1'b0;
    bus.decon    = 1'b0;
    bus.clr      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pcm", 32'(bus.pcm), 32'd0);
    check("rst_ch", 32'(bus.pcm_ch), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // round A
    slot(8'h07, 1'b1, 1'b1, 1'b0);
    check("t1_pcm30", 32'(bus.pcm), 32'd30);
    slot_n(4'd8, 1'b1, 1'b0);
    check("t2_neg2", 32'(bus.pcm), 32'hFFE);
    slot_n(4'd7, 1'b1, 1'b0);
    prev2 = bus.pcm;
    slot_n(4'd5, 1'b1, 1'b0);
    skip();
    skip();
    // round B
    slot_n(4'd0, 1'b1, 1'b0);
    check("t1_pcm34", 32'(bus.pcm), 32'd34);
    slot_n(4'd4, 1'b1, 1'b0);
    check("t2_pcm16", 32'(bus.pcm), 32'd16);
    slot_n(4'd7, 1'b1, 1'b0);
    prev2 = bus.pcm;
    skip();
    skip();
    skip();
    // drive channel 2 into idx saturation and wrap
    for (int r = 3; r <= 10; r++) begin
      skip();
      skip();
      slot_n(4'd7, 1'b1, 1'b0);
      if (r >= 8) begin
        diff = bus.pcm - prev2;
        check("wrap_delta", 32'(diff), 32'd2910);
      end
      prev2 = bus.pcm;
      skip();
      skip();
      skip();
    end
    // clr beats decon on channel 3
    skip();
    skip();
    skip();
    slot_n(4'd7, 1'b1, 1'b1);
    check("clr_pcm", 32'(bus.pcm), 32'd0);
    skip();
    skip();
    skip();
    skip();
    skip();
    slot_n(4'd7, 1'b1, 1'b0);
    check("clr_idx0", 32'(bus.pcm), 32'd30);
    skip();
    skip();

    for (int i = 0; i < 600; i++) rand_slot();

    // mid-stream asynchronous reset
    rst = 1'b1;
    #1;
    check("arst_pcm", 32'(bus.pcm), 32'd0);
    check("arst_ch", 32'(bus.pcm_ch), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("rst3_pcm", 32'(bus.pcm), 32'd0);
    check("rst3_ch", 32'(bus.pcm_ch), 32'd1);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 60; i++) rand_slot();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
